data_memory_multicycle: RTL and testbench

Multi-cycle data memory for the Memory stage of the pipelined datapath. It accepts one load or store per access and holds `mem_ready` low for a programmable number of cycles. The hazard unit uses that low `mem_ready` to stall the F/D/E/M/W stages. It sits directly downstream of the E/M pipeline register and feeds `read_data` into the M/W register.

---
 rtl/data_memory_multicycle.sv | 150 +++++++++++++++
 tb/tb_data_memory_multicycle.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_multicycle.sv
// data_memory_multicycle
//
// Multi-cycle data memory for the Memory stage. A load or store is accepted
// from IDLE and mem_ready is held low for LATENCY cycles in total, counting
// the request cycle. The hazard unit uses the low mem_ready to stall the
// pipeline. The access commits on the edge that enters DONE. In DONE,
// mem_ready is high and read_data is valid.
//
// Handshake: mem_ready is the only flow-control signal. A request
// (mem_read | mem_write) is presented in IDLE and held by the pipeline. The
// access has completed in the first cycle where mem_ready is high again;
// the pipeline advances on that cycle's edge. The request inputs are
// sampled only in IDLE. In BUSY and DONE they are ignored.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   mem_read     load request
//   mem_write    store request (wins over mem_read when both are set)
//   address      byte address; word index = address[DEPTH_LOG2+1:2]
//   write_data   store data
//   read_data    registered load result; holds until the next completed load
//   mem_ready    high = no access pending, or access completing this cycle
//   stall_count  wrapping count of clock edges with mem_ready low
//   state        FSM state for observation (0=IDLE, 1=BUSY, 2=DONE)
module data_memory_multicycle #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic [31:0] stall_count,
  output logic [1:0]  state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The counter is loaded with the number of BUSY cycles still to go after
  // the first one, so it reaches zero in the last BUSY cycle.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  // The array has no reset. This initialiser zero-fills it in simulation.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic                  req;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           data_q;
  logic                  wr_q;
  logic [3:0]            cnt;

  logic                  commit_en;
  logic                  commit_wr;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic [31:0]           commit_data;

  // Upper address bits alias and the byte-offset bits are dropped.
  logic unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign req_idx          = address[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{address[31:DEPTH_LOG2+2], address[1:0]};

  // mem_ready in IDLE depends on req combinationally. This lets the hazard
  // unit stall in the same cycle the request appears.
  always_comb begin
    mem_ready = 1'b1;
    case (state)
      IDLE:    mem_ready = !req;
      BUSY:    mem_ready = 1'b0;
      DONE:    mem_ready = 1'b1;
      default: mem_ready = 1'b1;
    endcase
  end

  // Commit source. It is normally the latched request. With LATENCY == 1
  // the access commits straight out of IDLE, so the live inputs are used.
  always_comb begin
    commit_en   = 1'b0;
    commit_wr   = wr_q;
    commit_idx  = idx_q;
    commit_data = data_q;
    case (state)
      IDLE: begin
        if (req && (LATENCY <= 1)) begin
          commit_en   = 1'b1;
          commit_wr   = mem_write;
          commit_idx  = req_idx;
          commit_data = write_data;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) commit_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      read_data   <= '0;
      stall_count <= '0;
      cnt         <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
    end else begin
      if (!mem_ready) stall_count <= stall_count + 32'd1;

      if (commit_en && !commit_wr) read_data <= mem[commit_idx];

      case (state)
        IDLE: begin
          if (req) begin
            idx_q  <= req_idx;
            data_q <= write_data;
            wr_q   <= mem_write;
            cnt    <= CNT_LOAD;
            state  <= (LATENCY > 1) ? BUSY : DONE;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        // A request still present in DONE is the access just completed.
        // It is never restarted.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (commit_en && commit_wr && !reset) mem[commit_idx] <= commit_data;
  end

endmodule

// File: tb/tb_data_memory_multicycle.sv
// tb_data_memory_multicycle
//
// Bench for data_memory_multicycle (DEPTH_LOG2=8, LATENCY=4). Driver tasks
// issue accesses and push the expected DONE-cycle response into exp_q. The
// response is computed from a word-array model of the memory. A monitor on
// the falling edge measures each low run of mem_ready. When mem_ready
// returns high it pops and compares read_data, stall_count and the run
// length.
module tb_data_memory_multicycle;

  localparam int DL  = 8;
  localparam int LAT = 4;
  localparam int W   = 96;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic [31:0] stall_count;
  logic [1:0]  state;

  always #5 clk = ~clk;

  data_memory_multicycle #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .mem_ready   (mem_ready),
    .stall_count (stall_count),
    .state       (state)
  );

  int n_vec = 0;
  int n_err = 0;

  // {read_data, stall_count, cycles with mem_ready low}
  logic [W-1:0] exp_q[$];

  logic [31:0] model_mem [256];
  logic [31:0] model_rd;
  logic [31:0] model_stall;

  int          run_len;
  bit          chk_idle;
  logic [W-1:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Monitor: checks each completed access and the IDLE cycle after it.
  always @(negedge clk) begin
    if (reset) begin
      run_len  = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("idle_after_done", {30'd0, state}, 32'd0);
        chk_idle = 0;
      end
      if (!mem_ready) begin
        run_len++;
      end else if (run_len > 0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got completion, wanted none pending");
        end else begin
          exp_e = exp_q.pop_front();
          check("read_data", read_data, exp_e[95:64]);
          check("stall_count", stall_count, exp_e[63:32]);
          check("ready_low_cycles", 32'(run_len), exp_e[31:0]);
        end
        run_len  = 0;
        chk_idle = 1;
      end
    end
  end

  // Entered and left at posedge+1. Holds reset for n edges, then checks the
  // reset state.
  task automatic do_reset(input int n);
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset       = 1'b0;
    model_stall = '0;
    model_rd    = '0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_stall_count", stall_count, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1. Presents a request and holds it until mem_ready
  // returns high. The request is then dropped at the next posedge+1. With
  // scramble set, address and data are randomised while the access is in
  // flight.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble);
    int idx;
    int k;
    idx = int'((addr >> 2) % 256);
    if (wr)      model_mem[idx] = data;
    else if (rd) model_rd       = model_mem[idx];
    model_stall = model_stall + 32'(LAT);
    exp_q.push_back({model_rd, model_stall, 32'(LAT)});

    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (scramble && !mem_ready && k >= 1) begin
        // Cycle k+1 onward is past the sampling edge, so changes must be ignored.
        @(posedge clk);
        #1;
        address    = $urandom;
        write_data = $urandom;
        @(negedge clk);
        k++;
      end
    end while (!mem_ready && k < 50);
    if (!mem_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL access_timeout: got mem_ready=0 after %0d cycles, wanted 1", k);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    int          k;

    foreach (model_mem[i]) model_mem[i] = '0;
    model_rd    = '0;
    model_stall = '0;
    run_len     = 0;
    chk_idle    = 0;
    address     = '0;
    write_data  = '0;

    // Reset state.
    do_reset(2);

    // Store, then load back the same word.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Back-to-back loads, with the second presented in the cycle after DONE.
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);

    // A store aborted by reset in its second BUSY cycle must not commit.
    mem_write  = 1'b1;
    address    = 32'h20;
    write_data = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset(1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Read and write together act as a write. Address 0x403 aliases to word 0.
    access(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
    access(1'b1, 1'b1, 32'h403, 32'hA5A5A5A5, 1'b0);
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomised mix over 16 words, with aliased upper bits and random byte offsets.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, $urandom,
             bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, wanted 0", exp_q.size());
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
